depthwise_engine: RTL and testbench



---
 rtl/depthwise_pkg.sv | 57 +++++
 rtl/depthwise_engine_lane.sv | 77 +++++++
 rtl/depthwise_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_depthwise_engine.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/depthwise_pkg.sv
// -----------------------------------------------------------------------------
// depthwise_pkg
// Shared definitions for the depthwise convolution engine:
//   - acc_width()  : accumulator width for a K*K product sum
//   - state_e      : control FSM states
//   - LATENCY      : accept-to-output pipeline depth
//   - beat_tag_t   : per-beat control tag that travels beside the datapath
//   - round_sat()  : round-half-up right shift followed by signed saturation
// -----------------------------------------------------------------------------
package depthwise_pkg;

    localparam int LATENCY = 4;
    localparam int GROUP_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic               valid;
        logic               last;
        logic [GROUP_W-1:0] group;
    } beat_tag_t;

    function automatic int acc_width(input int data_width, input int kernel_size);
        return 2 * data_width + $clog2(kernel_size * kernel_size);
    endfunction

    // Works at 64 bits so neither the rounding offset nor the shift can overflow;
    // the caller truncates the already-saturated result to data_width bits.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] value,
        input logic        [4:0]  shift,
        input int                 data_width
    );
        logic signed [63:0] rounded;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        rounded = value;
        if (shift != 5'd0) begin
            rounded = value + (64'sd1 <<< (shift - 5'd1));
        end
        rounded = rounded >>> shift;
        max_v   = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (data_width - 1));
        if (rounded > max_v) begin
            return max_v;
        end else if (rounded < min_v) begin
            return min_v;
        end else begin
            return rounded;
        end
    endfunction

endpackage

// File: rtl/depthwise_engine_lane.sv
// -----------------------------------------------------------------------------
// dw_lane
// One channel lane of the depthwise engine: K*K signed multiplies, an adder
// tree and the bias add, as three registered stages that all hold when en=0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the pipeline (low during a global stall)
//   feature    : K*K signed features, tap k at [k*DW +: DW]
//   weight     : K*K signed weights, same packing
//   bias       : signed bias for the beat currently in stage 1
//   acc        : stage-3 result, sum of products plus bias
// -----------------------------------------------------------------------------
module dw_lane
    import depthwise_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int ACC_W       = acc_width(DATA_WIDTH, KERNEL_SIZE),
    parameter int SUM_W       = ACC_W + 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        en,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] feature,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] weight,
    input  logic signed [2*DATA_WIDTH-1:0]              bias,
    output logic signed [SUM_W-1:0]                     acc
);

    localparam int TAPS   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0]       prod_q [TAPS];
    logic signed [PROD_W-1:0]       prod_d [TAPS];
    logic signed [ACC_W-1:0]        sum_q;
    logic signed [ACC_W-1:0]        sum_d;
    logic signed [2*DATA_WIDTH-1:0] bias_q;
    logic signed [2*DATA_WIDTH-1:0] bias_d;
    logic signed [SUM_W-1:0]        acc_q;
    logic signed [SUM_W-1:0]        acc_d;

    // The bias add keeps one extra bit so a full-scale sum plus a full-scale
    // bias cannot wrap before saturation.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = $signed(feature[k*DATA_WIDTH +: DATA_WIDTH])
                      * $signed(weight[k*DATA_WIDTH +: DATA_WIDTH]);
        end
        sum_d = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_d = sum_d + ACC_W'(prod_q[k]);
        end
        bias_d = bias;
        acc_d  = SUM_W'(sum_q) + SUM_W'(bias_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= '0;
            end
            sum_q  <= '0;
            bias_q <= '0;
            acc_q  <= '0;
        end else if (en) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= prod_d[k];
            end
            sum_q  <= sum_d;
            bias_q <= bias_d;
            acc_q  <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/depthwise_engine.sv
// -----------------------------------------------------------------------------
// depthwise_engine
// Computes one output pixel of a depthwise convolution: accepts one K*K window
// beat per channel group of CP lanes, then emits one result beat per group
// (bias add, rounding shift, saturation, optional ReLU) with valid/ready flow.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   cfg_channel/bias_base/shift/relu: layer configuration, latched on start
//   start, busy, done               : pixel control (done is a 1-cycle pulse)
//   win_valid/ready/feature/weight  : window beat input stream
//   bias_we/waddr/wdata             : bias table write port
//   out_valid/ready/data/group/last : result beat output stream
// -----------------------------------------------------------------------------
module depthwise_engine
    import depthwise_pkg::*;
#(
    parameter int DATA_WIDTH          = 16,
    parameter int KERNEL_SIZE         = 3,
    parameter int CHANNEL_PARALLELISM = 4,
    parameter int MAX_CHANNELS        = 128,
    parameter int BIAS_DEPTH          = 256
) (
    input  logic                                                        clk,
    input  logic                                                        rst_n,
    input  logic [7:0]                                                  cfg_channel,
    input  logic [7:0]                                                  cfg_bias_base,
    input  logic [4:0]                                                  cfg_shift,
    input  logic                                                        cfg_relu,
    input  logic                                                        start,
    output logic                                                        busy,
    input  logic                                                        win_valid,
    output logic                                                        win_ready,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE*CHANNEL_PARALLELISM-1:0] win_feature,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE*CHANNEL_PARALLELISM-1:0] win_weight,
    input  logic                                                        bias_we,
    input  logic [7:0]                                                  bias_waddr,
    input  logic [2*DATA_WIDTH-1:0]                                     bias_wdata,
    output logic                                                        out_valid,
    input  logic                                                        out_ready,
    output logic [DATA_WIDTH*CHANNEL_PARALLELISM-1:0]                   out_data,
    output logic [7:0]                                                  out_group,
    output logic                                                        out_last,
    output logic                                                        done
);

    localparam int CP      = CHANNEL_PARALLELISM;
    localparam int LANE_W  = DATA_WIDTH * KERNEL_SIZE * KERNEL_SIZE;
    localparam int ACC_W   = acc_width(DATA_WIDTH, KERNEL_SIZE);
    localparam int SUM_W   = ACC_W + 1;
    localparam int BIAS_AW = $clog2(BIAS_DEPTH);
    localparam int TAG_N   = LATENCY - 1;

    // Control state
    state_e             state_q,     state_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [GROUP_W-1:0] group_q,     group_d;
    logic [7:0]         remaining_q, remaining_d;
    logic [7:0]         ch_q,        ch_d;
    logic [7:0]         base_q,      base_d;
    logic [4:0]         shift_q,     shift_d;
    logic               relu_q,      relu_d;

    // Beat tags for stages 1..3 and the output register
    beat_tag_t                        tag_q [TAG_N];
    beat_tag_t                        tag_d [TAG_N];
    logic                             out_valid_q, out_valid_d;
    logic [DATA_WIDTH*CP-1:0]         out_data_q,  out_data_d;
    logic [7:0]                       out_group_q, out_group_d;
    logic                             out_last_q,  out_last_d;

    logic                             stall;
    logic                             win_accept;
    logic signed [2*DATA_WIDTH-1:0]   bias_mem [BIAS_DEPTH];
    logic signed [2*DATA_WIDTH-1:0]   bias_rd  [CP];
    logic signed [SUM_W-1:0]          lane_acc [CP];

    assign stall      = out_valid_q && !out_ready;
    assign win_ready  = (state_q == RUN) && !stall && (remaining_q != 8'd0);
    assign win_accept = win_valid && win_ready;

    // Bias table is deliberately left unreset so values survive a pixel abort.
    always_ff @(posedge clk) begin
        if (bias_we) begin
            bias_mem[BIAS_AW'(32'(bias_waddr) % BIAS_DEPTH)] <= bias_wdata;
        end
    end

    // Bias is looked up for the beat sitting in stage 1 so that it lands in the
    // lane beside the adder-tree result.
    always_comb begin
        for (int i = 0; i < CP; i++) begin
            bias_rd[i] = bias_mem[BIAS_AW'((32'(base_q) + 32'(tag_q[0].group) + 32'(i)) % BIAS_DEPTH)];
        end
    end

    for (genvar i = 0; i < CP; i++) begin : g_lane
        dw_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .KERNEL_SIZE (KERNEL_SIZE),
            .ACC_W       (ACC_W),
            .SUM_W       (SUM_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (!stall),
            .feature (win_feature[i*LANE_W +: LANE_W]),
            .weight  (win_weight[i*LANE_W +: LANE_W]),
            .bias    (bias_rd[i]),
            .acc     (lane_acc[i])
        );
    end

    // Pixel sequencing. A start in the done cycle is ignored so that a start
    // held high cannot immediately retrigger the engine.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        group_d     = group_q;
        remaining_d = remaining_q;
        ch_d        = ch_q;
        base_d      = base_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    ch_d    = cfg_channel;
                    base_d  = cfg_bias_base;
                    shift_d = cfg_shift;
                    relu_d  = cfg_relu;
                    group_d = '0;
                    if (cfg_channel == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        remaining_d = 8'((32'(cfg_channel) + CP - 1) / CP);
                        busy_d      = 1'b1;
                        state_d     = RUN;
                    end
                end
            end
            RUN: begin
                if (win_accept) begin
                    group_d     = group_q + GROUP_W'(CP);
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Tag pipeline and stage 4. Everything holds as one while stalled, which
    // keeps the output register stable until the consumer takes it.
    always_comb begin
        for (int s = 0; s < TAG_N; s++) begin
            tag_d[s] = tag_q[s];
        end
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_group_d = out_group_q;
        out_last_d  = out_last_q;
        if (!stall) begin
            tag_d[0].valid = win_accept;
            tag_d[0].last  = (remaining_q == 8'd1);
            tag_d[0].group = group_q;
            for (int s = 1; s < TAG_N; s++) begin
                tag_d[s] = tag_q[s-1];
            end
            out_valid_d = tag_q[TAG_N-1].valid;
            out_group_d = tag_q[TAG_N-1].group[7:0];
            out_last_d  = tag_q[TAG_N-1].last;
            for (int i = 0; i < CP; i++) begin
                if (!tag_q[TAG_N-1].valid
                    || (32'(tag_q[TAG_N-1].group) + 32'(i) >= 32'(ch_q))) begin
                    out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                end else begin
                    out_data_d[i*DATA_WIDTH +: DATA_WIDTH] =
                        DATA_WIDTH'(round_sat(64'(lane_acc[i]), shift_q, DATA_WIDTH));
                    if (relu_q && out_data_d[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
                        out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            group_q     <= '0;
            remaining_q <= '0;
            ch_q        <= '0;
            base_q      <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            for (int s = 0; s < TAG_N; s++) begin
                tag_q[s] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_group_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            group_q     <= group_d;
            remaining_q <= remaining_d;
            ch_q        <= ch_d;
            base_q      <= base_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            for (int s = 0; s < TAG_N; s++) begin
                tag_q[s] <= tag_d[s];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_group_q <= out_group_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_group = out_group_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_depthwise_engine.sv
// -----------------------------------------------------------------------------
// tb_depthwise_engine
// Directed self-checking bench for depthwise_engine (DW=16, K=3, CP=4).
// Each scenario loads window beats with hand-computed expected result beats,
// starts a pixel and checks every output handshake, stall behaviour and done.
// -----------------------------------------------------------------------------
module tb_depthwise_engine;

    localparam int DW    = 16;
    localparam int K     = 3;
    localparam int CP    = 4;
    localparam int TAPS  = K * K;
    localparam int VEC_W = DW * TAPS * CP;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         cfg_channel = '0;
    logic [7:0]         cfg_bias_base = '0;
    logic [4:0]         cfg_shift = '0;
    logic               cfg_relu = 1'b0;
    logic               start = 1'b0;
    logic               busy;
    logic               win_valid = 1'b0;
    logic               win_ready;
    logic [VEC_W-1:0]   win_feature = '0;
    logic [VEC_W-1:0]   win_weight = '0;
    logic               bias_we = 1'b0;
    logic [7:0]         bias_waddr = '0;
    logic [2*DW-1:0]    bias_wdata = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [DW*CP-1:0]   out_data;
    logic [7:0]         out_group;
    logic               out_last;
    logic               done;

    int test_count = 0;
    int fail_count = 0;

    logic [VEC_W-1:0]   beat_f [8];
    logic [VEC_W-1:0]   beat_w [8];
    logic [DW*CP-1:0]   exp_d  [8];
    int                 exp_g  [8];
    logic               exp_l  [8];

    depthwise_engine #(
        .DATA_WIDTH          (DW),
        .KERNEL_SIZE         (K),
        .CHANNEL_PARALLELISM (CP),
        .MAX_CHANNELS        (128),
        .BIAS_DEPTH          (256)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_channel   (cfg_channel),
        .cfg_bias_base (cfg_bias_base),
        .cfg_shift     (cfg_shift),
        .cfg_relu      (cfg_relu),
        .start         (start),
        .busy          (busy),
        .win_valid     (win_valid),
        .win_ready     (win_ready),
        .win_feature   (win_feature),
        .win_weight    (win_weight),
        .bias_we       (bias_we),
        .bias_waddr    (bias_waddr),
        .bias_wdata    (bias_wdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_group     (out_group),
        .out_last      (out_last),
        .done          (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Lane l gets value v_l on taps 0..ntaps-1, zero on the remaining taps.
    function automatic logic [VEC_W-1:0] mkVec(input int v0, input int v1, input int v2,
                                               input int v3, input int ntaps);
        logic [VEC_W-1:0] v;
        int vals [4];
        vals = '{v0, v1, v2, v3};
        v = '0;
        for (int l = 0; l < CP; l++) begin
            for (int t = 0; t < ntaps; t++) begin
                v[(l*TAPS + t)*DW +: DW] = DW'(vals[l]);
            end
        end
        return v;
    endfunction

    function automatic logic [DW*CP-1:0] packLanes(input int a, input int b,
                                                   input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic setBeat(input int b, input logic [VEC_W-1:0] f, input logic [VEC_W-1:0] w,
                           input logic [DW*CP-1:0] e, input int g, input logic l);
        beat_f[b] = f;
        beat_w[b] = w;
        exp_d[b]  = e;
        exp_g[b]  = g;
        exp_l[b]  = l;
    endtask

    task automatic writeBias(input int addr, input int data);
        @(negedge clk);
        bias_we    = 1'b1;
        bias_waddr = 8'(addr);
        bias_wdata = 32'(data);
        @(negedge clk);
        bias_we    = 1'b0;
    endtask

    // Pulses start for one cycle with the given configuration.
    task automatic applyStimulus(input int ch, input int base, input int shift, input int relu);
        @(negedge clk);
        cfg_channel   = 8'(ch);
        cfg_bias_base = 8'(base);
        cfg_shift     = 5'(shift);
        cfg_relu      = 1'(relu);
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("busy_after_start", busy, (ch != 0));
    endtask

    // Streams nb beats, drops out_ready for stall_len cycles from stall_at,
    // checks every output handshake against the expected tables and the done pulse.
    task automatic runPixel(input string tag, input int nb, input int stall_at,
                            input int stall_len);
        int beat_in = 0;
        int beat_out = 0;
        bit expect_done = 0;
        bit finished = 0;
        bit holding = 0;
        logic [127:0] held = '0;
        for (int cyc = 0; cyc < 80 && !finished; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            win_valid = (beat_in < nb);
            if (beat_in < nb) begin
                win_feature = beat_f[beat_in];
                win_weight  = beat_w[beat_in];
            end
            #1;
            if (expect_done) begin
                checkOutput($sformatf("%s_done", tag), done, 1'b1);
                checkOutput($sformatf("%s_busy_at_done", tag), busy, 1'b0);
                finished = 1;
            end else if (done) begin
                checkOutput($sformatf("%s_early_done", tag), done, 1'b0);
            end
            if (out_valid && !out_ready) begin
                checkOutput($sformatf("%s_win_ready_stall", tag), win_ready, 1'b0);
                if (holding) begin
                    checkOutput($sformatf("%s_hold", tag), {out_last, out_group, out_data}, held);
                end
                held    = {out_last, out_group, out_data};
                holding = 1;
            end else begin
                holding = 0;
            end
            if (win_valid && win_ready) begin
                beat_in++;
            end
            if (out_valid && out_ready && !finished) begin
                if (beat_out < nb) begin
                    checkOutput($sformatf("%s_b%0d_data", tag, beat_out), out_data, exp_d[beat_out]);
                    checkOutput($sformatf("%s_b%0d_group", tag, beat_out), out_group, exp_g[beat_out]);
                    checkOutput($sformatf("%s_b%0d_last", tag, beat_out), out_last, exp_l[beat_out]);
                end
                if (out_last) begin
                    expect_done = 1;
                end
                beat_out++;
            end
        end
        win_valid = 1'b0;
        out_ready = 1'b1;
        checkOutput($sformatf("%s_finished", tag), finished, 1'b1);
        checkOutput($sformatf("%s_beats", tag), beat_out, nb);
    endtask

    initial begin
        logic [VEC_W-1:0] ones;
        ones = mkVec(1, 1, 1, 1, TAPS);

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_win_ready", win_ready, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_out_group", out_group, '0);
        checkOutput("rst_out_last", out_last, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bias table: zeros for the plain tests, distinct values around the wrap
        for (int a = 16; a < 48; a++) begin
            writeBias(a, 0);
        end
        writeBias(254, 100);
        writeBias(255, -50);
        writeBias(0, 7);
        writeBias(1, -3);

        // Two full groups of unit data
        setBeat(0, ones, ones, packLanes(9, 9, 9, 9), 0, 1'b0);
        setBeat(1, ones, ones, packLanes(9, 9, 9, 9), 4, 1'b1);
        applyStimulus(8, 16, 0, 0);
        runPixel("ch8", 2, 100, 0);

        // Partial final group: lanes 2,3 beyond cfg_channel read zero
        setBeat(1, ones, ones, packLanes(9, 9, 0, 0), 4, 1'b1);
        applyStimulus(6, 16, 0, 0);
        runPixel("ch6", 2, 100, 0);

        // Saturation both ways, then ReLU on the negative lanes
        setBeat(0, mkVec(32767, 32767, 32767, 32767, TAPS),
                   mkVec(32767, 32767, -32767, -32767, TAPS),
                   packLanes(32767, 32767, -32768, -32768), 0, 1'b1);
        applyStimulus(4, 16, 0, 0);
        runPixel("sat", 1, 100, 0);
        exp_d[0] = packLanes(32767, 32767, 0, 0);
        applyStimulus(4, 16, 0, 1);
        runPixel("relu", 1, 100, 0);

        // Rounding with shift 1: sums 3, -3, 9, -9
        setBeat(0, mkVec(1, 1, 1, 1, 3), mkVec(1, -1, 3, -3, TAPS),
                packLanes(2, -1, 5, -4), 0, 1'b1);
        applyStimulus(4, 16, 1, 0);
        runPixel("round", 1, 100, 0);

        // Bias addressing wraps from 255 to 0
        setBeat(0, ones, ones, packLanes(109, -41, 16, 6), 0, 1'b1);
        applyStimulus(4, 254, 0, 0);
        runPixel("wrap", 1, 100, 0);

        // Eight groups with out_ready low for 5 cycles mid-stream
        for (int b = 0; b < 8; b++) begin
            setBeat(b, mkVec(b + 1, b + 1, b + 1, b + 1, TAPS), ones,
                    packLanes(9*(b+1), 9*(b+1), 9*(b+1), 9*(b+1)), 4*b, (b == 7));
        end
        applyStimulus(32, 16, 0, 0);
        runPixel("stall", 8, 5, 5);

        // Zero channels: immediate done; start held into the done cycle is ignored
        @(negedge clk);
        cfg_channel = 8'd0;
        start       = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("ch0_done", done, 1'b1);
        checkOutput("ch0_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("ch0_start_on_done_ignored", done, 1'b0);
        checkOutput("ch0_no_output", out_valid, 1'b0);

        // Reset while draining
        setBeat(0, ones, ones, packLanes(9, 9, 9, 9), 0, 1'b0);
        applyStimulus(8, 16, 0, 0);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            win_valid   = 1'b1;
            win_feature = ones;
            win_weight  = ones;
            #1;
            checkOutput($sformatf("drain_accept%0d", b), win_ready, 1'b1);
        end
        @(negedge clk);
        win_valid = 1'b0;
        #1;
        checkOutput("drain_busy", busy, 1'b1);
        checkOutput("drain_win_ready", win_ready, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_out_valid", out_valid, 1'b0);
        checkOutput("midrst_out_data", out_data, '0);
        checkOutput("midrst_out_last", out_last, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("postrst_c%0d", c), {done, out_valid}, 2'b00);
        end

        // Bias written before the reset is still there
        setBeat(0, ones, ones, packLanes(109, -41, 16, 6), 0, 1'b1);
        applyStimulus(4, 254, 0, 0);
        runPixel("wrap_after_reset", 1, 100, 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
